result_frame_tx: RTL and testbench
==================================

// Module: result_frame_tx
// PURPOSE
//  Autonomous transmitter for inference results: the send side of the host result protocol.
//  - On each inference completion, snapshots predicted digit + 10 class scores.
//  - Serialises them as one framed, checksummed packet through the shared uart_tx byte interface.
//  - Sits beside digit_reader/scores_reader in top; so host no longer polls with 0xCC/0xCD.
// PARAMETERS
//  SOF_BYTE     8'hA5  frame start-of-frame byte
//  NUM_CLASSES  10     class scores per frame
//  SCORE_BYTES  4      bytes per signed 32-bit score, little-endian
//  BUSY_WAIT    4      max cycles to wait for tx_busy to assert after tx_send
// PORTS
//  clk            in   1    system clock (100 MHz), single clock domain
//  rst            in   1    asynchronous, active-low reset
//  start          in   1    1-cycle pulse: inference_done rising edge
//  digit_in       in   4    predicted digit, valid while start=1
//  scores_in      in   320  class scores; bits [32k+31:32k] = class k, valid while start=1
//  tx_grant       in   1    1 = this block may drive uart_tx this cycle (arbiter grant)
//  tx_busy        in   1    uart_tx busy
//  tx_data        out  8    byte to uart_tx
//  tx_send        out  1    1-cycle send strobe to uart_tx
//  busy           out  1    frame in progress (request line to arbiter)
//  frame_done     out  1    1-cycle pulse after final byte accepted
// BEHAVIOUR
//  Reset: all state is cleared asynchronously when rst=0.
//   - Output values: tx_data=0, tx_send=0, busy=0, frame_done=0.
//   - Internal state: FSM=IDLE, byte index=0, checksum=0, pending=0.
//  Frame format: 43 bytes, in this order.
//   - Byte 0: SOF_BYTE.
//   - Byte 1: {4'h0, digit}.
//   - Bytes 2..41: class 0..9, each sent LSB first.
//   - Byte 42: XOR of bytes 1..41 (SOF is excluded).
//  Snapshot: start registers digit_in and scores_in into internal holding regs.
//   - Later input changes do not affect the frame in flight.
//  FSM states:
//   - IDLE: on start, take snapshot, clear idx and chk, go to ARB. busy=1 from the next cycle.
//   - ARB: wait until tx_grant=1 and tx_busy=0.
//     - Drive tx_data=byte[idx] and tx_send=1 for exactly one cycle.
//     - chk ^= byte when 1<=idx<=41.
//     - Go to WAIT_HI.
//   - WAIT_HI: wait for tx_busy=1, or for BUSY_WAIT cycles to elapse (timeout counts as accepted).
//     Then go to WAIT_LO.
//   - WAIT_LO: wait for tx_busy=0.
//     - If idx==42: pulse frame_done and go to IDLE.
//     - Otherwise: idx++ and go to ARB.
//  tx_data holds its value from the send cycle until the next send.
//  tx_send never asserts while tx_busy=1 or tx_grant=0.
//  Byte mux: idx 2..41 selects score (idx-2)/4, byte (idx-2)%4.
//   - Implement as shift of the snapshot register or indexed select; no divider.
//  start while busy:
//   - A single pending flag latches the new digit and scores into a second snapshot.
//   - A newer start overwrites the pending snapshot (last wins).
//   - On frame_done, a pending frame starts the next cycle (IDLE is skipped, busy stays 1).
//  start on the same cycle as frame_done: treated as pending, same as above.
//  Reset mid-frame: abort immediately, no partial-frame recovery.
//   - Host resynchronises on SOF plus the checksum.
//  Throughput: one byte per uart_tx byte time plus at most 3 cycles of overhead.
// STRUCTURE
//  Shared package (nn_pkg):
//   - RESULT_SOF, RESULT_FRAME_LEN=43, CHK_IDX=42.
//   - FSM state encoding localparams.
//   - SCORE_W=32.
//  One natural sub-module: result_frame_mux.
//   - Combinational idx -> byte select over the snapshot.
//   - Unit-testable separately.
//  Checksum and FSM stay in this module.
//  In top: tx arbiter gives digit/scores readers priority.
//   - tx_grant = ~(digit_tx_send | scores_tx_send | reader_active).
// TESTING
//  1. Basic frame: digit=7, score k=k*256-1000, start pulse, uart_tx model.
//     -> 43 bytes: A5,07, then scores LE, chk=XOR of bytes 1..41; frame_done once; busy low after.
//  2. Negative/extreme scores: class0=32'h80000000, class9=32'hFFFFFFFF, others 0.
//     -> bytes 2..5=00 00 00 80, 38..41=FF FF FF FF; chk matches.
//  3. Back-to-back: second start (digit=3) at byte 10 of frame 1.
//     -> frame 1 unaltered; frame 2 begins with A5,03 with no idle gap; two frame_done pulses.
//  4. Arbitration: hold tx_grant=0 for 500 cycles at byte 20.
//     -> no tx_send while grant=0; resumes with byte 20 and no skip or duplicate.
//  5. Busy timeout: tx_busy never asserts.
//     -> after each send, BUSY_WAIT cycles then next byte; 43 strobes total; frame_done.
//  6. Async reset at byte 30 (rst low mid-cycle).
//     -> outputs 0 immediately; after release, IDLE; next start yields a full clean frame.

Source files
------------

// File: rtl/result_frame_tx_pkg.sv
// Shared constants and types for the inference result frame transmitter.
// Frame: SOF, digit, little-endian class scores, XOR checksum.
package result_frame_tx_pkg;

    localparam logic [7:0] RESULT_SOF = 8'hA5;
    localparam int SCORE_W = 32;
    localparam int NUM_CLASSES_DEF = 10;
    localparam int SCORE_BYTES_DEF = 4;
    localparam int BUSY_WAIT_DEF = 4;
    localparam int RESULT_FRAME_LEN = 2 + NUM_CLASSES_DEF * SCORE_BYTES_DEF + 1;
    localparam int CHK_IDX = RESULT_FRAME_LEN - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARB,
        ST_WAIT_HI,
        ST_WAIT_LO
    } tx_state_e;

    function automatic int chk_pos(input int nc, input int sb);
        return 2 + nc * sb;
    endfunction

endpackage

// File: rtl/result_frame_mux.sv
// Frame byte selector: maps a byte index onto SOF, digit, score bytes
// or checksum. Score bytes come from a shift of the snapshot, no divider.
module result_frame_mux
    import result_frame_tx_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE = RESULT_SOF,
    parameter int NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int SCORE_BYTES = SCORE_BYTES_DEF,
    parameter int IDX_W = 6
) (
    input  logic [IDX_W-1:0]                     idx,
    input  logic [3:0]                           digit,
    input  logic [NUM_CLASSES*SCORE_BYTES*8-1:0] scores,
    input  logic [7:0]                           chk,
    output logic [7:0]                           data
);

    localparam int SW = NUM_CLASSES * SCORE_BYTES * 8;
    localparam int CHK_POS = chk_pos(NUM_CLASSES, SCORE_BYTES);

    logic [IDX_W-1:0] sel;
    logic [SW-1:0]    shifted;

    // Flattened scores are already little-endian per class, so byte
    // (idx-2) of the vector is exactly class (idx-2)/4, byte (idx-2)%4.
    assign sel = idx - IDX_W'(2);
    assign shifted = scores >> {sel, 3'b000};

    always_comb begin
        data = chk;
        unique case (1'b1)
            (idx == '0):
                data = SOF_BYTE;
            (idx == IDX_W'(1)):
                data = {4'h0, digit};
            (idx >= IDX_W'(2) && idx < IDX_W'(CHK_POS)):
                data = shifted[7:0];
            default:
                data = chk;
        endcase
    end

endmodule

// File: rtl/result_frame_tx.sv
// Autonomous result frame transmitter: snapshots digit and scores on
// start and serialises a checksummed frame through the uart_tx handshake.
module result_frame_tx
    import result_frame_tx_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE = RESULT_SOF,
    parameter int NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int SCORE_BYTES = SCORE_BYTES_DEF,
    parameter int BUSY_WAIT = BUSY_WAIT_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [3:0]                           digit_in,
    input  logic [NUM_CLASSES*SCORE_BYTES*8-1:0] scores_in,
    input  logic                                 tx_grant,
    input  logic                                 tx_busy,
    output logic [7:0]                           tx_data,
    output logic                                 tx_send,
    output logic                                 busy,
    output logic                                 frame_done
);

    localparam int SW = NUM_CLASSES * SCORE_BYTES * 8;
    localparam int CHK_POS = chk_pos(NUM_CLASSES, SCORE_BYTES);
    localparam int IDX_W = $clog2(CHK_POS + 1);
    localparam int WC_W = $clog2(BUSY_WAIT + 1);

    tx_state_e        state_q;
    tx_state_e        state_d;
    logic [IDX_W-1:0] idx_q;
    logic [7:0]       chk_q;
    logic [WC_W-1:0]  wcnt_q;
    logic [7:0]       data_q;
    logic             done_q;

    logic [3:0]       cur_digit_q;
    logic [SW-1:0]    cur_scores_q;
    logic             pend_q;
    logic [3:0]       pend_digit_q;
    logic [SW-1:0]    pend_scores_q;

    logic [7:0]       byte_now;
    logic             send;
    logic             last;
    logic             accepted;
    logic             finish;
    logic             load_new;
    logic             load_next;
    logic             chk_byte;

    result_frame_mux #(
        .SOF_BYTE    (SOF_BYTE),
        .NUM_CLASSES (NUM_CLASSES),
        .SCORE_BYTES (SCORE_BYTES),
        .IDX_W       (IDX_W)
    ) u_mux (
        .idx    (idx_q),
        .digit  (cur_digit_q),
        .scores (cur_scores_q),
        .chk    (chk_q),
        .data   (byte_now)
    );

    // Strobe is combinational so it can never fire against a lost grant
    // or a busy transmitter in the same cycle.
    assign send = (state_q == ST_ARB) && tx_grant && !tx_busy;
    assign last = (idx_q == IDX_W'(CHK_POS));
    assign accepted = (state_q == ST_WAIT_LO) && !tx_busy;
    assign finish = accepted && last;
    assign load_new = (state_q == ST_IDLE) && start;
    assign load_next = finish && (pend_q || start);
    assign chk_byte = (idx_q != '0) && !last;

    assign tx_send = send;
    assign tx_data = send ? byte_now : data_q;
    assign busy = (state_q != ST_IDLE);
    assign frame_done = done_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_ARB;
            end
            ST_ARB: begin
                if (send) state_d = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (tx_busy || wcnt_q == WC_W'(BUSY_WAIT - 1))
                    state_d = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                if (accepted) begin
                    if (!last) state_d = ST_ARB;
                    else if (pend_q || start) state_d = ST_ARB;
                    else state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q <= '0;
            chk_q <= '0;
            wcnt_q <= '0;
            data_q <= '0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q <= finish;
            if (state_q == ST_WAIT_HI) wcnt_q <= wcnt_q + WC_W'(1);
            else wcnt_q <= '0;
            if (send) begin
                data_q <= byte_now;
                if (chk_byte) chk_q <= chk_q ^ byte_now;
            end
            if (load_new || load_next) begin
                idx_q <= '0;
                chk_q <= '0;
            end else if (accepted && !last) begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    // Active and pending snapshots; a start during a frame (or on its
    // final cycle) overwrites the pending copy, so the newest wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_digit_q <= '0;
            cur_scores_q <= '0;
            pend_q <= 1'b0;
            pend_digit_q <= '0;
            pend_scores_q <= '0;
        end else begin
            if (load_new || (load_next && start)) begin
                cur_digit_q <= digit_in;
                cur_scores_q <= scores_in;
            end else if (load_next) begin
                cur_digit_q <= pend_digit_q;
                cur_scores_q <= pend_scores_q;
            end
            if (load_next) begin
                pend_q <= 1'b0;
            end else if (start && state_q != ST_IDLE) begin
                pend_q <= 1'b1;
                pend_digit_q <= digit_in;
                pend_scores_q <= scores_in;
            end
        end
    end

endmodule

// File: tb/tb_result_frame_tx.sv
// Directed bench for result_frame_tx: uart_tx busy model, byte
// scoreboard fed at each start, frame length and handshake checks.
module tb_result_frame_tx;

    localparam int BW = 4;
    localparam int FLEN = 43;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   digit_in = '0;
    logic [319:0] scores_in = '0;
    logic         tx_grant = 1'b1;
    logic         tx_busy;
    logic [7:0]   tx_data;
    logic         tx_send;
    logic         busy;
    logic         frame_done;

    always #5 clk = ~clk;

    result_frame_tx dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .digit_in   (digit_in),
        .scores_in  (scores_in),
        .tx_grant   (tx_grant),
        .tx_busy    (tx_busy),
        .tx_data    (tx_data),
        .tx_send    (tx_send),
        .busy       (busy),
        .frame_done (frame_done)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    int uart_len = 10;
    bit uart_on = 1'b1;
    int busy_cnt = 0;
    assign tx_busy = (busy_cnt != 0);

    always @(posedge clk or negedge rst) begin
        if (!rst) busy_cnt <= 0;
        else if (tx_send && uart_on) busy_cnt <= uart_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    int fbytes = 0;
    int sends = 0;
    int done_cnt = 0;
    int cyc = 0;
    int last_send = 0;
    bit gap_chk = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            fbytes = 0;
        end else begin
            if (frame_done) begin
                done_cnt++;
                chk("frame_len", fbytes, FLEN);
                fbytes = 0;
            end
            if (tx_send) begin
                chk("send_busy", {31'b0, tx_busy}, 0);
                chk("send_grant", {31'b0, tx_grant}, 1);
                if (gap_chk && fbytes != 0)
                    chk("gap", {31'b0, (cyc - last_send >= BW + 1 &&
                        cyc - last_send <= BW + 3)}, 1);
                if (exp_q.size() == 0) begin
                    chk("extra_byte", {24'b0, tx_data}, 32'hFFFF_FFFF);
                end else begin
                    chk($sformatf("byte%0d", fbytes), {24'b0, tx_data},
                        {24'b0, exp_q.pop_front()});
                end
                fbytes++;
                sends++;
                last_send = cyc;
            end
        end
    end

    task automatic push_frame(input logic [3:0] d, input logic [319:0] s);
        logic [7:0] c;
        logic [7:0] b;
        exp_q.push_back(8'hA5);
        b = {4'h0, d};
        c = b;
        exp_q.push_back(b);
        for (int k = 0; k < 40; k++) begin
            b = s[k*8 +: 8];
            c ^= b;
            exp_q.push_back(b);
        end
        exp_q.push_back(c);
    endtask

    task automatic fire(input logic [3:0] d, input logic [319:0] s);
        @(posedge clk);
        #1;
        start = 1'b1;
        digit_in = d;
        scores_in = s;
        push_frame(d, s);
        @(posedge clk);
        #1;
        start = 1'b0;
        digit_in = ~d;
        scores_in = ~s;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        for (int i = 0; i < budget && fbytes < n; i++) @(negedge clk);
        chk("wait_bytes", {31'b0, fbytes >= n}, 1);
    endtask

    task automatic wait_done(input int n, input int budget);
        for (int i = 0; i < budget && done_cnt < n; i++) @(negedge clk);
        chk("wait_done", {31'b0, done_cnt >= n}, 1);
    endtask

    logic [319:0] s1;
    logic [319:0] s2;
    int s0;

    initial begin
        for (int k = 0; k < 10; k++) s1[k*32 +: 32] = k * 256 - 1000;
        s2 = '0;
        s2[31:0] = 32'h8000_0000;
        s2[319:288] = 32'hFFFF_FFFF;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", {24'b0, tx_data}, 0);
        chk("rst_send", {31'b0, tx_send}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, frame_done}, 0);
        rst = 1'b1;

        fire(4'd7, s1);
        wait_done(1, 3000);
        repeat (3) @(negedge clk);
        chk("t1_busy_low", {31'b0, busy}, 0);
        chk("t1_q_empty", exp_q.size(), 0);

        fire(4'd2, s2);
        wait_done(2, 3000);

        fire(4'd5, s1);
        wait_bytes(10, 3000);
        fire(4'd3, s2);
        wait_done(3, 3000);
        chk("t3_busy_kept", {31'b0, busy}, 1);
        wait_done(4, 3000);
        repeat (3) @(negedge clk);
        chk("t3_busy_low", {31'b0, busy}, 0);
        chk("t3_q_empty", exp_q.size(), 0);

        fire(4'd1, s1);
        wait_bytes(20, 3000);
        @(posedge clk);
        #1;
        tx_grant = 1'b0;
        s0 = sends;
        repeat (500) @(posedge clk);
        #1;
        chk("t4_no_send", sends, s0);
        chk("t4_held_idx", fbytes, 20);
        tx_grant = 1'b1;
        wait_done(5, 3000);

        uart_on = 1'b0;
        gap_chk = 1'b1;
        fire(4'd8, s2);
        wait_done(6, 3000);
        gap_chk = 1'b0;
        uart_on = 1'b1;
        chk("t5_q_empty", exp_q.size(), 0);

        fire(4'd4, s1);
        wait_bytes(30, 3000);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("t6_data", {24'b0, tx_data}, 0);
        chk("t6_send", {31'b0, tx_send}, 0);
        chk("t6_busy", {31'b0, busy}, 0);
        chk("t6_done", {31'b0, frame_done}, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("t6_idle", {31'b0, busy}, 0);
        fire(4'd6, s2);
        wait_done(7, 3000);
        repeat (3) @(negedge clk);
        chk("t6_q_empty", exp_q.size(), 0);
        chk("done_total", done_cnt, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
